unidad_riesgos_multiciclo: RTL

UNIDAD_RIESGOS_MULTICICLO -- requirements
Module: unidad_riesgos_multiciclo

---
 rtl/unidad_riesgos_multiciclo_if.sv | 34 +++
 rtl/unidad_riesgos_multiciclo.sv | 116 +++++++++++
 2 files changed

// File: rtl/unidad_riesgos_multiciclo_if.sv
// Bundle of pipeline hazard-detection signals between the pipeline datapath
// (master) and the multi-cycle hazard unit (slave).
interface unidad_riesgos_multiciclo_if #(
  parameter int NB_REG  = 5,
  parameter int NB_PERF = 32
);
  logic              i_enable;
  logic [NB_REG-1:0] i_rs_ID;
  logic [NB_REG-1:0] i_rt_ID;
  logic              i_uses_rs_ID;
  logic              i_uses_rt_ID;
  logic              i_branch_ID;
  logic [NB_REG-1:0] i_rd_EX;
  logic              i_reg_write_EX;
  logic              i_mem_read_EX;
  logic [NB_REG-1:0] i_rd_MEM;
  logic              i_mem_read_MEM;
  logic              i_flush;
  logic              o_stall;
  logic              o_busy;
  logic [NB_PERF-1:0] o_stall_cycles;

  modport master (
    output i_enable, i_rs_ID, i_rt_ID, i_uses_rs_ID, i_uses_rt_ID, i_branch_ID,
    output i_rd_EX, i_reg_write_EX, i_mem_read_EX, i_rd_MEM, i_mem_read_MEM, i_flush,
    input  o_stall, o_busy, o_stall_cycles
  );

  modport slave (
    input  i_enable, i_rs_ID, i_rt_ID, i_uses_rs_ID, i_uses_rt_ID, i_branch_ID,
    input  i_rd_EX, i_reg_write_EX, i_mem_read_EX, i_rd_MEM, i_mem_read_MEM, i_flush,
    output o_stall, o_busy, o_stall_cycles
  );
endinterface

// File: rtl/unidad_riesgos_multiciclo.sv
// Multi-cycle hazard unit: detects load-use and branch-in-ID hazards, holds the
// front of the pipeline for the required number of cycles, counts stall cycles.
module unidad_riesgos_multiciclo #(
  parameter int NB_REG            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int NB_PERF           = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  unidad_riesgos_multiciclo_if.slave  bus
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LOAD_N    = CNT_W'(LOAD_STALL_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_N_BR = CNT_W'(LOAD_STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE_N     = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [NB_PERF-1:0] stall_cycles_q, stall_cycles_d;

  logic [NB_REG-1:0]  rs_id, rt_id, rd_ex, rd_mem;
  logic               ex_hit, mem_hit;
  logic [CNT_W-1:0]   need_n;
  logic               stall;

  assign rs_id  = bus.i_rs_ID;
  assign rt_id  = bus.i_rt_ID;
  assign rd_ex  = bus.i_rd_EX;
  assign rd_mem = bus.i_rd_MEM;

  // A source only matches when it is really read and is not register 0.
  always_comb begin
    ex_hit  = (bus.i_uses_rs_ID && (rs_id != '0) && (rs_id == rd_ex)) ||
              (bus.i_uses_rt_ID && (rt_id != '0) && (rt_id == rd_ex));
    mem_hit = (bus.i_uses_rs_ID && (rs_id != '0) && (rs_id == rd_mem)) ||
              (bus.i_uses_rt_ID && (rt_id != '0) && (rt_id == rd_mem));
  end

  // Required stall length; the longest applicable condition wins.
  always_comb begin
    need_n = '0;
    if (ex_hit && bus.i_mem_read_EX) begin
      need_n = bus.i_branch_ID ? LOAD_N_BR : LOAD_N;
    end else if (bus.i_branch_ID && ex_hit && bus.i_reg_write_EX) begin
      need_n = ONE_N;
    end
    if (bus.i_branch_ID && mem_hit && bus.i_mem_read_MEM && (need_n == '0)) begin
      need_n = ONE_N;
    end
  end

  // Next-state logic; flush beats both detection and the step enable.
  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    stall_cycles_d = stall_cycles_q;
    stall          = 1'b0;

    if (!i_reset && !bus.i_flush) begin
      stall = (state_q == STALL) || (need_n != '0);
    end

    if (bus.i_flush) begin
      state_d  = IDLE;
      remain_d = '0;
    end else if (bus.i_enable) begin
      case (state_q)
        IDLE: begin
          if (need_n > ONE_N) begin
            state_d  = STALL;
            remain_d = need_n - ONE_N;
          end
        end
        STALL: begin
          if (remain_q <= ONE_N) begin
            state_d  = IDLE;
            remain_d = '0;
          end else begin
            remain_d = remain_q - ONE_N;
          end
        end
        default: begin
          state_d  = IDLE;
          remain_d = '0;
        end
      endcase
    end

    if (bus.i_enable && stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + NB_PERF'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= IDLE;
      remain_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.o_stall        = stall;
  assign bus.o_busy         = (state_q == STALL);
  assign bus.o_stall_cycles = stall_cycles_q;

endmodule
